// File: rtl/rv_imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package rv_imem_loader_pkg;

  typedef enum logic [2:0] {
    LD_CLEAR,
    LD_HDR0,
    LD_HDR1,
    LD_DATA,
    LD_DONE,
    LD_ERR
  } t_ld_state;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/rv_byte_to_word.sv
// Assembles little-endian bytes into 32-bit words; word_vld pulses in the
// same cycle the fourth byte is accepted, with the full word on 'word'.
module rv_byte_to_word (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        xfer,
  input  logic [7:0]  byte_data,
  output logic        word_vld,
  output logic [31:0] word
);

  logic [1:0]  byte_idx;
  logic [23:0] sh;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_idx <= '0;
      sh       <= '0;
    end else if (xfer) begin
      byte_idx <= byte_idx + 2'd1;
      sh       <= {byte_data, sh[23:8]};
    end
  end

  // Combinational so the loader can register the write one cycle after b3.
  always_comb begin
    word_vld = xfer && (byte_idx == 2'd3);
    word     = {byte_data, sh};
  end

endmodule

// File: rtl/rv_imem_loader.sv
// Boot loader: clears IMEM to NOPs, then writes a length-prefixed LE word
// stream into it, holding the CPU in reset until the load completes.
module rv_imem_loader #(
  parameter int unsigned IMEM_SIZE_WORDS = 256,
  parameter int unsigned ADDR_W          = $clog2(IMEM_SIZE_WORDS),
  parameter logic [31:0] NOP_INSTR       = rv_imem_loader_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_rst_out,
  output logic              load_done,
  output logic              load_err
);

  import rv_imem_loader_pkg::t_ld_state;
  import rv_imem_loader_pkg::LD_CLEAR;
  import rv_imem_loader_pkg::LD_HDR0;
  import rv_imem_loader_pkg::LD_HDR1;
  import rv_imem_loader_pkg::LD_DATA;
  import rv_imem_loader_pkg::LD_DONE;
  import rv_imem_loader_pkg::LD_ERR;

  t_ld_state       state, nxt;
  logic [ADDR_W:0] clr_idx;
  logic [ADDR_W:0] word_idx;
  logic [15:0]     cnt;
  logic [15:0]     hdr;
  logic            xfer;
  logic            clr_done;
  logic            last_word;
  logic            word_vld;
  logic [31:0]     word;

  rv_byte_to_word u_b2w (
    .clk      (clk),
    .rst      (rst),
    .clr      (state != LD_DATA),
    .xfer     (xfer && (state == LD_DATA)),
    .byte_data(byte_data),
    .word_vld (word_vld),
    .word     (word)
  );

  always_comb begin
    xfer      = byte_valid && byte_ready;
    hdr       = {byte_data, cnt[7:0]};
    clr_done  = (32'(clr_idx) == IMEM_SIZE_WORDS);
    last_word = ((32'(word_idx) + 32'd1) == 32'(cnt));
    nxt       = state;
    case (state)
      LD_CLEAR: if (clr_done) nxt = LD_HDR0;
      LD_HDR0:  if (xfer) nxt = LD_HDR1;
      LD_HDR1: begin
        if (xfer) begin
          if (hdr == 16'd0)                      nxt = LD_DONE;
          else if (32'(hdr) > IMEM_SIZE_WORDS)   nxt = LD_ERR;
          else                                   nxt = LD_DATA;
        end
      end
      LD_DATA:  if (word_vld && last_word) nxt = LD_DONE;
      LD_DONE,
      LD_ERR:   if (load_start) nxt = LD_CLEAR;
      default:  nxt = LD_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LD_CLEAR;
      clr_idx      <= '0;
      word_idx     <= '0;
      cnt          <= '0;
      byte_ready   <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_rst_out  <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state       <= nxt;
      imem_wr_en  <= 1'b0;
      byte_ready  <= (nxt == LD_HDR0) || (nxt == LD_HDR1) || (nxt == LD_DATA);
      load_done   <= (nxt == LD_DONE);
      load_err    <= (nxt == LD_ERR);
      // Low only on the second and later DONE cycles.
      cpu_rst_out <= !((state == LD_DONE) && (nxt == LD_DONE));
      case (state)
        LD_CLEAR: begin
          if (!clr_done) begin
            imem_wr_en   <= 1'b1;
            imem_wr_addr <= clr_idx[ADDR_W-1:0];
            imem_wr_data <= NOP_INSTR;
            clr_idx      <= clr_idx + 1'b1;
          end
        end
        LD_HDR0: if (xfer) cnt[7:0] <= byte_data;
        LD_HDR1: begin
          if (xfer) begin
            cnt[15:8] <= byte_data;
            word_idx  <= '0;
          end
        end
        LD_DATA: begin
          if (word_vld) begin
            imem_wr_en   <= 1'b1;
            imem_wr_addr <= word_idx[ADDR_W-1:0];
            imem_wr_data <= word;
            word_idx     <= word_idx + 1'b1;
          end
        end
        LD_DONE,
        LD_ERR: begin
          // Word 0 of the clear is issued on the re-arm edge so CLEAR
          // still spans exactly IMEM_SIZE_WORDS cycles.
          if (load_start) begin
            imem_wr_en   <= 1'b1;
            imem_wr_addr <= '0;
            imem_wr_data <= NOP_INSTR;
            clr_idx      <= {{ADDR_W{1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
